// File: rtl/annunciator_uart_tx_pkg.sv
// rtl/annunciator_uart_tx_pkg.sv - shared UART state encodings and divider helper
package annunciator_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_REL   = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per bit; truncating division, so the line runs slightly fast
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/annunciator_uart_tx_baud_tick.sv
// rtl/annunciator_uart_tx_baud_tick.sv - bit-period counter producing one tick per DIV cycles
module uart_baud_tick #(
    parameter int DIV = 416
) (
    input  logic clk48,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The tick cycle is the last cycle of a bit period; the wrap happens on the same edge
    assign tick = (count_q == LAST);

    // Next count: synchronous clear wins, otherwise count up and wrap at DIV-1
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/annunciator_uart_tx.sv
// rtl/annunciator_uart_tx.sv - fetches bytes from the annunciator and sends them as 8N1 UART
module annunciator_uart_tx
    import annunciator_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FETCH_WAIT = 3,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       en,
    output logic       inc,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       sent
);

    localparam int DIV  = uart_div(CLK_HZ, BAUD);
    localparam int FW_W = $clog2(FETCH_WAIT);
    localparam logic [FW_W-1:0] FW_LAST = FW_W'(FETCH_WAIT - 1);
    localparam logic            SB_LAST = 1'(STOP_BITS - 1);

    uart_state_e     state_q, state_d;
    logic [FW_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            inc_q, inc_d;
    logic            busy_q, busy_d;

    logic baud_clr;
    logic baud_tick;
    logic last_stop;

    // Baud counter is held clear until the start bit, so the start bit is a full DIV long
    assign baud_clr  = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_REL);
    assign last_stop = (stop_cnt_q == SB_LAST);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk48 (clk48),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (baud_tick)
    );

    // sent must coincide with the final stop cycle, which is only known from the live tick
    assign sent = (state_q == ST_STOP) && baud_tick && last_stop;
    assign tx   = tx_q;
    assign inc  = inc_q;
    assign busy = busy_q;

    // Next-state, counters, shift register and the registered line outputs
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        shreg_d     = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_REQ;
                    fetch_cnt_d = '0;
                end
            end
            ST_REQ: begin
                // din is only trusted on the last inc-high cycle
                if (fetch_cnt_q == FW_LAST) begin
                    shreg_d = din;
                    state_d = ST_REL;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
            end
            ST_REL: begin
                fetch_cnt_d = '0;
                state_d     = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shreg_d   = {1'b1, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = ST_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        state_d     = en ? ST_REQ : ST_IDLE;
                        fetch_cnt_d = '0;
                        stop_cnt_d  = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inc_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shreg_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    // FSM and datapath registers; reset drives the line idle immediately
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_cnt_q <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shreg_q     <= 8'hFF;
            tx_q        <= 1'b1;
            inc_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
        end
    end

endmodule
